// File: rtl/cpu_traffic_pkg.sv
// Shared definitions for the per-CPU traffic generator.
//   state_t    : generator FSM states (GAP idle countdown, SEND word offered, DONE finished)
//   LFSR_POLY  : Galois feedback taps for the 32-bit right-shifting payload LFSR
//   IDX_LSB    : bit offset of the CPU index field inside a 64-bit word
//   CNT_LSB    : bit offset of the transaction-number field inside a 64-bit word
//   lfsr_next(): one step of the payload LFSR
package cpu_traffic_pkg;

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int IDX_LSB = 48;
    localparam int CNT_LSB = 32;

    // Galois form: shift right, fold the polynomial in when a 1 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/cpu_traffic_lfsr.sv
// 32-bit payload LFSR with synchronous load.
// Ports:
//   clk   : clock, posedge
//   load  : load seed this cycle (takes priority over en)
//   en    : advance one step
//   seed  : value loaded while load=1 (must be non-zero)
//   value : current LFSR state
module cpu_traffic_lfsr
    import cpu_traffic_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (load) begin
            lfsr_reg <= seed;
        end else if (en) begin
            lfsr_reg <= lfsr_next(lfsr_reg);
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/cpu_traffic_gen.sv
// Per-CPU traffic source: sends NB_TRANSACTIONS 64-bit words on a valid/ready
// stream with pseudo-random idle gaps, then raises a sticky done flag.
// Word layout: [63:48] CPU index, [47:32] transaction number, [31:0] LFSR payload.
// Ports:
//   clk               : clock, posedge
//   rst               : synchronous active-high reset
//   cpu_index         : instance id, captured only while rst=1
//   data_rdy          : sink ready
//   data_vld          : word valid (held until accepted)
//   data              : word payload (stable while data_vld=1 and data_rdy=0)
//   transactions_done : sticky, set the cycle after the last word is accepted
module cpu_traffic_gen
    import cpu_traffic_pkg::*;
#(
    parameter int          NB_TRANSACTIONS = 16,
    parameter int          MAX_GAP_LOG2    = 2,
    parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_index,
    input  logic        data_rdy,
    output logic        data_vld,
    output logic [63:0] data,
    output logic        transactions_done
);

    localparam logic [MAX_GAP_LOG2-1:0] GAP_ONE = MAX_GAP_LOG2'(1);

    state_t                  state_reg,   state_next;
    logic [MAX_GAP_LOG2-1:0] gap_cnt_reg, gap_cnt_next;
    logic [31:0]             txn_cnt_reg, txn_cnt_next;
    logic [15:0]             idx_reg;
    logic                    data_vld_reg, data_vld_next;
    logic [63:0]             data_reg,     data_next;
    logic                    done_reg,     done_next;

    logic [31:0]             seed_mix;
    logic [31:0]             seed_eff;
    logic [31:0]             lfsr_cur;
    logic [MAX_GAP_LOG2-1:0] gap_after_xfer;
    logic [31:0]             txn_inc;
    logic                    xfer;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    assign seed_mix = LFSR_SEED ^ cpu_index;
    assign seed_eff = (seed_mix == 32'h0) ? 32'h1 : seed_mix;

    assign xfer    = data_vld_reg & data_rdy;
    assign txn_inc = txn_cnt_reg + 32'd1;

    // The gap after an acceptance comes from the LFSR value the transfer
    // is about to produce, i.e. the payload of the next word.
    assign gap_after_xfer = MAX_GAP_LOG2'(lfsr_next(lfsr_cur));

    cpu_traffic_lfsr u_lfsr (
        .clk   (clk),
        .load  (rst),
        .en    (xfer),
        .seed  (seed_eff),
        .value (lfsr_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= (NB_TRANSACTIONS == 0) ? DONE : GAP;
            gap_cnt_reg  <= seed_eff[MAX_GAP_LOG2-1:0];
            txn_cnt_reg  <= 32'd0;
            idx_reg      <= cpu_index[15:0];
            data_vld_reg <= 1'b0;
            data_reg     <= 64'd0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gap_cnt_reg  <= gap_cnt_next;
            txn_cnt_reg  <= txn_cnt_next;
            data_vld_reg <= data_vld_next;
            data_reg     <= data_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gap_cnt_next  = gap_cnt_reg;
        txn_cnt_next  = txn_cnt_reg;
        data_vld_next = data_vld_reg;
        data_next     = data_reg;

        case (state_reg)
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    data_vld_next                = 1'b1;
                    data_next[IDX_LSB +: 16]     = idx_reg;
                    data_next[CNT_LSB +: 16]     = txn_cnt_reg[15:0];
                    data_next[CNT_LSB-1:0]       = lfsr_cur;
                    state_next                   = SEND;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_ONE;
                end
            end
            SEND: begin
                // Word and valid are held untouched until the sink accepts.
                if (xfer) begin
                    txn_cnt_next  = txn_inc;
                    data_vld_next = 1'b0;
                    if (txn_inc == 32'(NB_TRANSACTIONS)) begin
                        state_next = DONE;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = gap_after_xfer;
                    end
                end
            end
            DONE: begin
                data_vld_next = 1'b0;
            end
            default: begin
                state_next    = GAP;
                data_vld_next = 1'b0;
            end
        endcase

        // Registered so the flag shows up the cycle after the final acceptance
        // (or the first cycle after reset when there is nothing to send).
        done_next = (state_next == DONE);
    end

    assign data_vld          = data_vld_reg;
    assign data              = data_reg;
    assign transactions_done = done_reg;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
`timescale 1ns/1ps
module tb_cpu_traffic_gen;

    localparam int          N        = 8;
    localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY     = 32'h8020_0003;

    // 0..3 random ready, 4 always ready (cpu 3), 5 zero transactions,
    // 6 seed-zero corner, 7 backpressure + mid-stream reset.
    localparam int          NB_A   [N] = '{16, 16, 16, 16, 16, 0, 16, 16};
    localparam logic [31:0] IDX_A  [N] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd3, 32'd9, 32'd5, 32'd7};
    localparam logic [31:0] SEED_A [N] = '{DEF_SEED, DEF_SEED, DEF_SEED, DEF_SEED,
                                           DEF_SEED, DEF_SEED, 32'd5, DEF_SEED};

    logic        clk;
    logic        rst_a  [N];
    logic        rdy_a  [N];
    logic        vld_a  [N];
    logic [63:0] data_a [N];
    logic        done_a [N];
    logic        rdy7;

    int          vectors     = 0;
    int          miscompares = 0;
    int          acc_a    [N];
    logic [31:0] first_pl [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        cpu_traffic_gen dut (
            .clk               (clk),
            .rst               (rst_a[gi]),
            .cpu_index         (IDX_A[gi]),
            .data_rdy          (rdy_a[gi]),
            .data_vld          (vld_a[gi]),
            .data              (data_a[gi]),
            .transactions_done (done_a[gi])
        );
    end

    cpu_traffic_gen u_ready (
        .clk (clk), .rst (rst_a[4]), .cpu_index (IDX_A[4]), .data_rdy (rdy_a[4]),
        .data_vld (vld_a[4]), .data (data_a[4]), .transactions_done (done_a[4])
    );

    cpu_traffic_gen #(.NB_TRANSACTIONS(0)) u_zero (
        .clk (clk), .rst (rst_a[5]), .cpu_index (IDX_A[5]), .data_rdy (rdy_a[5]),
        .data_vld (vld_a[5]), .data (data_a[5]), .transactions_done (done_a[5])
    );

    cpu_traffic_gen #(.LFSR_SEED(32'd5)) u_seed (
        .clk (clk), .rst (rst_a[6]), .cpu_index (IDX_A[6]), .data_rdy (rdy_a[6]),
        .data_vld (vld_a[6]), .data (data_a[6]), .transactions_done (done_a[6])
    );

    cpu_traffic_gen u_ctrl (
        .clk (clk), .rst (rst_a[7]), .cpu_index (IDX_A[7]), .data_rdy (rdy_a[7]),
        .data_vld (vld_a[7]), .data (data_a[7]), .transactions_done (done_a[7])
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input int inst,
                         input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x >> 1) ^ (((x & 32'd1) != 32'd0) ? POLY : 32'd0);
    endfunction

    // Ready drivers: one process owns every ready line.
    initial begin
        for (int i = 0; i < N; i++) rdy_a[i] = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (i < 4 || i == 5) rdy_a[i] = 1'($urandom_range(0, 1));
                else if (i == 7)     rdy_a[i] = rdy7;
                else                 rdy_a[i] = 1'b1;
            end
        end
    end

    // ---------------- scoreboards / monitors ----------------
    for (genvar gi = 0; gi < N; gi++) begin : g_mon
        initial begin
            logic [63:0] exp_q[$];
            logic [31:0] lf;
            logic [63:0] prev_data;
            bit          armed, prev_rst, prev_vld, prev_rdy;
            armed = 0; prev_rst = 0; prev_vld = 0; prev_rdy = 0; prev_data = '0;
            acc_a[gi]    = 0;
            first_pl[gi] = '0;
            forever begin
                @(negedge clk);
                if (prev_rst) begin
                    // The edge just passed was a reset edge: outputs cleared,
                    // reference stream rebuilt from scratch.
                    check("rst_vld",  gi, 64'(vld_a[gi]),  64'd0);
                    check("rst_data", gi, data_a[gi],      64'd0);
                    check("rst_done", gi, 64'(done_a[gi]), 64'd0);
                    exp_q.delete();
                    acc_a[gi]    = 0;
                    first_pl[gi] = '0;
                    lf = SEED_A[gi] ^ IDX_A[gi];
                    if (lf == 32'd0) lf = 32'd1;
                    for (int k = 0; k < NB_A[gi]; k++) begin
                        exp_q.push_back({IDX_A[gi][15:0], 16'(k), lf});
                        lf = step(lf);
                    end
                    armed = 1;
                end else if (armed) begin
                    check("done", gi, 64'(done_a[gi]), 64'(acc_a[gi] == NB_A[gi]));
                    if (acc_a[gi] == NB_A[gi])
                        check("idle_after_done", gi, 64'(vld_a[gi]), 64'd0);
                    if (prev_vld && !prev_rdy) begin
                        check("hold_vld",  gi, 64'(vld_a[gi]), 64'd1);
                        check("hold_data", gi, data_a[gi],     prev_data);
                    end
                    if (!rst_a[gi] && vld_a[gi] && rdy_a[gi] && exp_q.size() > 0) begin
                        check("word", gi, data_a[gi], exp_q.pop_front());
                        if (acc_a[gi] == 0) first_pl[gi] = data_a[gi][31:0];
                        $display("inst=%0d accept word=%h", gi, data_a[gi]);
                        acc_a[gi]++;
                    end
                end
                prev_rst  = rst_a[gi];
                prev_vld  = vld_a[gi];
                prev_rdy  = rdy_a[gi];
                prev_data = data_a[gi];
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int          cyc;
        logic [63:0] held;
        bit          all_done;

        rdy7 = 1'b0;
        for (int i = 0; i < N; i++) rst_a[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) rst_a[i] = 1'b0;

        // Backpressure: hold ready low 5 cycles once the first word appears.
        cyc = 0;
        while (!vld_a[7] && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("ctrl_first_valid", 7, 64'(vld_a[7]), 64'd1);
        held = data_a[7];
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_vld",  7, 64'(vld_a[7]), 64'd1);
            check("bp_data", 7, data_a[7],     held);
        end
        rdy7 = 1'b1;

        // Reset mid-stream after 7 accepted words.
        cyc = 0;
        while (acc_a[7] < 7 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        check("ctrl_seven_accepted", 7, 64'(acc_a[7]), 64'd7);
        rst_a[7] = 1'b1;
        @(posedge clk); #1;
        rst_a[7] = 1'b0;
        check("ctrl_rst_vld",  7, 64'(vld_a[7]),  64'd0);
        check("ctrl_rst_done", 7, 64'(done_a[7]), 64'd0);

        // Let everything finish, bounded.
        cyc = 0; all_done = 0;
        while (!all_done && cyc < 5000) begin
            @(posedge clk); #1; cyc++;
            all_done = 1;
            for (int i = 0; i < N; i++) if (done_a[i] !== 1'b1) all_done = 0;
        end
        repeat (10) @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) begin
            check("final_done",  i, 64'(done_a[i]), 64'd1);
            check("final_count", i, 64'(acc_a[i]),  64'(NB_A[i]));
        end
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                check("payload_distinct", i, 64'(first_pl[i] != first_pl[j]), 64'd1);
        check("ready_word0_payload", 4, 64'(first_pl[4]), 64'h0000_0000_ACE1_246B);
        check("seed0_word0_payload", 6, 64'(first_pl[6]), 64'h0000_0000_0000_0001);
        check("ctrl_restart_payload", 7, 64'(first_pl[7]), 64'(DEF_SEED ^ 32'd7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
